muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle RV32M multiply/divide unit in the EX stage, beside the ALU. It takes the same two selected operands the ALU sees and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It holds the pipeline through a stall request until the result is ready. The EX result mux then steers its output into the EX/MEM register in place of the ALU result.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX holds an M-extension instruction; level, held high until the pipeline advances.
- flush  in  1  EX squash (branch/jump); aborts any operation.
- MdContrl  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Operand1  in  XLEN  rs1 value (dividend / multiplicand).
- Operand2  in  XLEN  rs2 value (divisor / multiplier).
- stall_req  out  1  to hazard unit: freeze IF/ID/EX, bubble MEM.
- done  out  1  one-cycle pulse; MdOut valid this cycle.
- MdOut  out  XLEN  result; holds last result until next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - latch op, operand magnitudes and result sign flags.
  - Special case or fast multiply: go to DONE.
  - Otherwise: load count=31 and go to CALC.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - count decrements each step; at count=0 go to DONE.
- DONE: done=1, apply sign fix-up, MdOut updated, go to IDLE unconditionally.
- start is ignored in CALC and DONE. The issuing instruction still drives start during DONE; it must not retrigger.
- Signed handling:
  - Signed operands are converted to magnitude; the unsigned result is negated if required.
  - Quotient is negative iff dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - MULHSU: Operand1 signed, Operand2 unsigned.
  - Product is formed at 64 bits; MUL returns [31:0], MULH* return [63:32].
- Special cases, no CALC:
  - divisor=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give Operand1.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- flush in any state: go to IDLE next cycle. No done pulse, MdOut unchanged.
- flush and start in the same IDLE cycle: flush wins, nothing accepted.
- rst: state IDLE, count=0, MdOut=0, done=0, stall_req=0.

## Timing
- stall_req = (IDLE & start & ~flush) | CALC. It is combinational, so the hazard unit stalls in the start cycle.
- stall_req is low in DONE, so the pipeline advances and EX/MEM captures MdOut.
- Iterative op: start at cycle 0, CALC in cycles 1–32, done in cycle 33. Pipeline stalled for 33 cycles.
- Special case or fast multiply: start at cycle 0, done in cycle 1, one stall cycle.
- Back-to-back M instructions: the next instruction is in EX in the cycle after DONE, with state back in IDLE. It is accepted that cycle, with no dead cycle.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - All four multiply ops use a single-cycle combinational 33x33 signed product and skip CALC (done in cycle 1).
  - Divide is unchanged.
- Not defined: multiply is iterative, 32 CALC cycles, same as divide.
- Results are bit-identical either way.

## Structure
- Shared header alongside Parameters.v holds:
  - MdContrl encodings (MD_MUL … MD_REMU).
  - State encodings.
  - Special-case constants.
- Sub-module muldiv_iter: one combinational step, either shift-add or shift-subtract.
  - Inputs: accumulator, remainder, operand registers, mode.
  - Outputs: next values.
- The FSM, counter, sign fix-up and special-case detection stay in muldiv_unit.

## Test plan
- DIVU 100 / 7 → done at cycle 33, MdOut=14; REMU same operands → 2; stall_req high cycles 0–32.
- DIV -7 / 2 → 0xFFFFFFFD (-3); REM -7 / 2 → 0xFFFFFFFF (-1); DIV 0x80000000 / -1 → 0x80000000 at cycle 1.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, both done at cycle 1.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE; MUL 3 × -4 → 0xFFFFFFF4.
- Run each multiply case with and without MULDIV_FAST_MUL_EN: expect cycle 1 vs cycle 33 done, identical values.
- flush at cycle 10 of DIVU: IDLE next cycle, no done, MdOut keeps the prior value. A new start with flush in the same cycle is not accepted. rst mid-CALC clears MdOut to 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   - MdContrl operation encodings (MD_MUL .. MD_REMU)
//   - FSM state encoding
//   - special-case result constants and the iteration counter start value
package muldiv_pkg;

    // MdContrl encodings; bit 2 set means a divide/remainder operation.
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } md_state_e;

    // Special-case constants.
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE       = 32'hFFFF_FFFF;

    // 32 radix-2 steps: the counter runs 31 down to 0.
    localparam logic [4:0] CALC_FIRST = 5'd31;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational radix-2 step of the iterative multiply/divide.
//   acc_i/acc_o   upper working register (product high half / partial remainder)
//   lo_i/lo_o     lower working register (multiplier then product low half /
//                 dividend then quotient)
//   opb_i         multiplicand (multiply) or divisor (divide) magnitude
//   div_mode_i    1: restoring shift-subtract, 0: shift-add
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic            div_mode_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] partial;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set, then shift
        // the 65-bit {carry, acc, lo} right by one.
        sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
        // Divide: shift {acc, lo} left by one and trial-subtract the divisor.
        partial = {acc_i, lo_i[XLEN-1]};
        diff    = partial - {1'b0, opb_i};

        if (div_mode_i) begin
            if (!diff[XLEN]) begin
                acc_o = diff[XLEN-1:0];
                lo_o  = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = partial[XLEN-1:0];
                lo_o  = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[XLEN:1];
            lo_o  = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on magnitudes with a final sign fix-up.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       EX holds an M instruction (level, held until the pipeline advances)
//   flush       EX squash; aborts any operation
//   MdContrl    operation select (see muldiv_pkg)
//   Operand1/2  rs1 / rs2 values
//   stall_req   freeze request to the hazard unit (combinational)
//   done        one-cycle pulse, MdOut valid
//   MdOut       result; holds the last result between operations
// Build option: define MULDIV_FAST_MUL_EN to compute all multiplies in one cycle with a
// combinational signed 33x33 product; divides stay iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      MdContrl,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] MdOut
);

    md_state_e       state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic            neg_q, neg_d;     // negate the magnitude result in DONE
    logic            spec_q, spec_d;   // result already final in res_q
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] md_out_q, md_out_d;

    // Operand decode for the issuing instruction.
    logic            op_is_div, op_is_rem;
    logic            a_signed, b_signed;
    logic            sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic            take_short;
    logic [XLEN-1:0] short_res;

    // Finishing logic.
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   mul_res, div_raw, div_fix, final_res;

    logic [XLEN-1:0] acc_step, lo_step;

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .acc_i      (acc_q),
        .lo_i       (lo_q),
        .opb_i      (opb_q),
        .div_mode_i (op_q[2]),
        .acc_o      (acc_step),
        .lo_o       (lo_step)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

    always_comb begin
        op_is_div = MdContrl[2];
        op_is_rem = (MdContrl == MD_REM) || (MdContrl == MD_REMU);
        a_signed  = (MdContrl == MD_MULH) || (MdContrl == MD_MULHSU) ||
                    (MdContrl == MD_DIV)  || (MdContrl == MD_REM);
        b_signed  = (MdContrl == MD_MULH) || (MdContrl == MD_DIV) || (MdContrl == MD_REM);
        sa        = a_signed & Operand1[XLEN-1];
        sb        = b_signed & Operand2[XLEN-1];
        a_mag     = sa ? -Operand1 : Operand1;
        b_mag     = sb ? -Operand2 : Operand2;

        div_zero  = op_is_div && (Operand2 == '0);
        div_ovf   = ((MdContrl == MD_DIV) || (MdContrl == MD_REM)) &&
                    (Operand1 == INT_MIN) && (Operand2 == NEG_ONE);

        if (div_zero) begin
            short_res = op_is_rem ? Operand1 : DIV_ZERO_QUOT;
        end else begin
            short_res = op_is_rem ? '0 : INT_MIN;
        end

`ifdef MULDIV_FAST_MUL_EN
        // Sign/zero-extended operands; the low 64 bits of the product equal the 33x33
        // signed product.
        fast_a    = {{XLEN{sa}}, Operand1};
        fast_b    = {{XLEN{sb}}, Operand2};
        fast_prod = fast_a * fast_b;
        if (!op_is_div) begin
            short_res = (MdContrl == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
        take_short = div_zero || div_ovf || !op_is_div;
`else
        take_short = div_zero || div_ovf;
`endif
    end

    // Sign fix-up of the iterative result.
    always_comb begin
        prod      = {acc_q, lo_q};
        prod_fix  = neg_q ? -prod : prod;
        mul_res   = (op_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        div_raw   = ((op_q == MD_REM) || (op_q == MD_REMU)) ? acc_q : lo_q;
        div_fix   = neg_q ? -div_raw : div_raw;
        final_res = spec_q ? res_q : (op_q[2] ? div_fix : mul_res);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        spec_d    = spec_q;
        res_d     = res_q;
        md_out_d  = md_out_q;
        stall_req = 1'b0;
        done      = 1'b0;
        MdOut     = md_out_q;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    stall_req = 1'b1;
                    op_d      = MdContrl;
                    // Quotient/product sign is the XOR; remainder follows the dividend.
                    neg_d     = op_is_rem ? sa : (sa ^ sb);
                    spec_d    = take_short;
                    res_d     = short_res;
                    acc_d     = '0;
                    if (op_is_div) begin
                        lo_d  = a_mag;
                        opb_d = b_mag;
                    end else begin
                        lo_d  = b_mag;
                        opb_d = a_mag;
                    end
                    if (take_short) begin
                        state_d = StDone;
                    end else begin
                        count_d = CALC_FIRST;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                stall_req = 1'b1;
                acc_d     = acc_step;
                lo_d      = lo_step;
                if (count_q == 5'd0) begin
                    state_d = StDone;
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            StDone: begin
                // start is still high from the issuing instruction; never retrigger here.
                state_d = StIdle;
                if (!flush) begin
                    done     = 1'b1;
                    MdOut    = final_res;
                    md_out_d = final_res;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            res_q    <= '0;
            md_out_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            spec_q   <= spec_d;
            res_q    <= res_d;
            md_out_q <= md_out_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed cases plus randomized
// back-to-back operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  MdContrl;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        stall_req;
    logic        done;
    logic [31:0] MdOut;

    int total;
    int bad;
    logic [31:0] last_res;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .MdContrl  (MdContrl),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .stall_req (stall_req),
        .done      (done),
        .MdOut     (MdOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference result from the RV32M rules using 64-bit integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] == 1'b0) return MulLat;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issues one op right after a rising edge (cycle 0) and follows it to done.
    // start is left high so a following call issues back-to-back.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        int stall_low;
        @(posedge clk);
        #1;
        start    = 1'b1;
        MdContrl = op;
        Operand1 = a;
        Operand2 = b;
        #1;
        cyc       = 0;
        stall_low = (stall_req !== 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done !== 1'b1 && stall_req !== 1'b1) stall_low++;
        end
        check_eq({tag, " latency"}, 32'(cyc), 32'(lat));
        check_eq({tag, " result"}, MdOut, exp);
        check_eq({tag, " stall in done"}, {31'd0, stall_req}, 32'd0);
        check_eq({tag, " stall gaps"}, 32'(stall_low), 32'd0);
        last_res = exp;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check_eq(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [31:0] corners [5];
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        total    = 0;
        bad      = 0;
        last_res = '0;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        MdContrl = '0;
        Operand1 = '0;
        Operand2 = '0;
        corners  = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("reset MdOut", MdOut, 32'd0);
        check_eq("reset done", {31'd0, done}, 32'd0);
        check_eq("reset stall", {31'd0, stall_req}, 32'd0);

        // Directed cases, issued back-to-back.
        run_op("divu 100/7",   3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu 100/7",   3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_op("div -7/2",     3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem -7/2",     3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu 5/0",     3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu 5/0",     3'd7, 32'd5, 32'd0, 32'd5, 1);
        run_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat);
        run_op("mulhsu -1*max",3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat);
        run_op("mulhu max*max",3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
        run_op("mul 3*-4",     3'd0, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, MulLat);

        // Randomized back-to-back operations against the reference model.
        for (int n = 0; n < 48; n++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom_range(0, 300); rb = $urandom_range(0, 20); end
                2: begin ra = corners[$urandom_range(0, 4)]; rb = corners[$urandom_range(0, 4)]; end
                default: begin ra = $urandom; rb = corners[$urandom_range(0, 4)]; end
            endcase
            run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, ref_md(rop, ra, rb),
                   ref_lat(rop, ra, rb));
        end

        // MdOut holds once the pipeline moves on.
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold MdOut", MdOut, last_res);

        // Flush in the middle of a DIVU: abort, no done, MdOut kept.
        @(posedge clk);
        #1;
        start    = 1'b1;
        MdContrl = 3'd5;
        Operand1 = 32'd1000;
        Operand2 = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check_eq("flush idle stall", {31'd0, stall_req}, 32'd0);
        check_eq("flush MdOut", MdOut, last_res);
        watch_no_done("flush no done", 40);
        check_eq("flush MdOut later", MdOut, last_res);

        // start together with flush in IDLE is not accepted.
        @(posedge clk);
        #1;
        start    = 1'b1;
        flush    = 1'b1;
        MdContrl = 3'd4;
        #1;
        check_eq("start+flush stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        #1;
        check_eq("start+flush not taken", {31'd0, stall_req}, 32'd0);
        watch_no_done("start+flush no done", 40);

        // Reset in the middle of CALC clears everything.
        @(posedge clk);
        #1;
        start    = 1'b1;
        MdContrl = 3'd3;
        Operand1 = 32'h1234_5678;
        Operand2 = 32'h9ABC_DEF0;
        repeat (5) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst mid MdOut", MdOut, 32'd0);
        check_eq("rst mid stall", {31'd0, stall_req}, 32'd0);
        watch_no_done("rst mid no done", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
